// File: rtl/hazard_ctrl.sv
// Pipeline interlock and forwarding controller: operand forward selects, load-use bubble,
// multi-cycle E-stage hold FSM and a saturating count of stalled cycles.
module hazard_ctrl #(
  parameter int unsigned SLOW_CYCLES = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       ern,
  input  logic             eslow,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [4:0]       mrn,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             dbubble,
  output logic             eholdn,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned REM_W = $clog2(SLOW_CYCLES + 1);
  // Remaining BUSY cycles after the first; unused when SLOW_CYCLES == 2.
  localparam logic [REM_W-1:0] REM_INIT =
      (SLOW_CYCLES > 2) ? REM_W'(SLOW_CYCLES - 3) : '0;

  typedef enum logic [1:0] {StRun, StBusy, StLast} state_e;

  state_e            r_state, w_state_d;
  logic [REM_W-1:0]  r_rem, w_rem_d;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_lu;

  // E has priority over M; register 0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic e_wr,
                                         input logic e_ld, input logic [4:0] e_rn,
                                         input logic m_wr, input logic m_ld,
                                         input logic [4:0] m_rn);
    if (e_wr && !e_ld && e_rn != 5'd0 && e_rn == src)      return 2'd1;
    else if (m_wr && !m_ld && m_rn != 5'd0 && m_rn == src) return 2'd2;
    else if (m_wr && m_ld && m_rn != 5'd0 && m_rn == src)  return 2'd3;
    else                                                   return 2'd0;
  endfunction

  // Operand forward selects, valid in every state.
  always_comb begin
    fwda = fwd_sel(rs, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
    fwdb = fwd_sel(rt, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
  end

  assign w_lu = ewreg & em2reg & (ern != 5'd0) &
                ((use_rs & (ern == rs)) | (use_rt & (ern == rt)));

  // Stall outputs and next state; LAST never looks at eslow (same op still in E).
  always_comb begin
    wpcir     = 1'b1;
    dbubble   = 1'b0;
    eholdn    = 1'b1;
    w_state_d = r_state;
    w_rem_d   = r_rem;
    unique case (r_state)
      StRun: begin
        if (eslow) begin
          wpcir  = 1'b0;
          eholdn = 1'b0;
          if (SLOW_CYCLES == 2) begin
            w_state_d = StLast;
          end else begin
            w_state_d = StBusy;
            w_rem_d   = REM_INIT;
          end
        end else if (w_lu) begin
          wpcir   = 1'b0;
          dbubble = 1'b1;
        end
      end
      StBusy: begin
        wpcir  = 1'b0;
        eholdn = 1'b0;
        if (r_rem == '0) w_state_d = StLast;
        else             w_rem_d   = r_rem - 1'b1;
      end
      StLast: begin
        if (w_lu) begin
          wpcir   = 1'b0;
          dbubble = 1'b1;
        end
        w_state_d = StRun;
      end
      default: w_state_d = StRun;
    endcase
  end

  // FSM state and remaining-cycle counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= StRun;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_d;
      r_rem   <= w_rem_d;
    end
  end

  // Saturating count of cycles with the front end held.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (!wpcir && r_cnt != {CNT_W{1'b1}}) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (main instance SLOW_CYCLES=4, CNT_W=4;
// a second instance with SLOW_CYCLES=2 shares the inputs).
module tb_hazard_ctrl;

  logic       clock, resetn;
  logic [4:0] rs, rt, ern, mrn;
  logic       use_rs, use_rt, ewreg, em2reg, eslow, mwreg, mm2reg;
  logic [1:0] fwda, fwdb, fwda2, fwdb2;
  logic       wpcir, dbubble, eholdn, wpcir2, dbubble2, eholdn2;
  logic [3:0]  stall_cnt;
  logic [15:0] stall_cnt2;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl #(.SLOW_CYCLES(4), .CNT_W(4)) dut (
    .clock(clock), .resetn(resetn), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .eslow(eslow), .mwreg(mwreg),
    .mm2reg(mm2reg), .mrn(mrn), .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir),
    .dbubble(dbubble), .eholdn(eholdn), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.SLOW_CYCLES(2), .CNT_W(16)) dut2 (
    .clock(clock), .resetn(resetn), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .eslow(eslow), .mwreg(mwreg),
    .mm2reg(mm2reg), .mrn(mrn), .fwda(fwda2), .fwdb(fwdb2), .wpcir(wpcir2),
    .dbubble(dbubble2), .eholdn(eholdn2), .stall_cnt(stall_cnt2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    rs = 0; rt = 0; use_rs = 0; use_rt = 0; ewreg = 0; em2reg = 0; ern = 0;
    eslow = 0; mwreg = 0; mm2reg = 0; mrn = 0;
  endtask

  initial begin
    clear_inputs();
    resetn = 1'b0;
    #12;
    chk("rst_wpcir", 16'(wpcir), 16'd1);
    chk("rst_eholdn", 16'(eholdn), 16'd1);
    chk("rst_dbubble", 16'(dbubble), 16'd0);
    chk("rst_cnt", 16'(stall_cnt), 16'd0);
    chk("rst_fwda", 16'(fwda), 16'd0);
    resetn = 1'b1;
    tick();

    // Forwarding priority and sources
    ewreg = 1; ern = 3; rs = 3; mwreg = 1; mrn = 3;
    #1;
    chk("fwd_e_prio", 16'(fwda), 16'd1);
    chk("fwd_b_none", 16'(fwdb), 16'd0);
    ern = 4;
    #1;
    chk("fwd_m_alu", 16'(fwda), 16'd2);
    mm2reg = 1; rt = 3;
    #1;
    chk("fwd_m_mem_a", 16'(fwda), 16'd3);
    chk("fwd_m_mem_b", 16'(fwdb), 16'd3);
    chk("fwd_no_stall", 16'(wpcir), 16'd1);
    tick();

    // Load-use bubble, then M-stage load data forwarded
    clear_inputs();
    ewreg = 1; em2reg = 1; ern = 5; use_rt = 1; rt = 5;
    #1;
    chk("lu_wpcir", 16'(wpcir), 16'd0);
    chk("lu_dbubble", 16'(dbubble), 16'd1);
    chk("lu_eholdn", 16'(eholdn), 16'd1);
    chk("lu_fwdb", 16'(fwdb), 16'd0);
    tick();
    clear_inputs();
    use_rt = 1; rt = 5; mwreg = 1; mm2reg = 1; mrn = 5;
    #1;
    chk("lu_next_fwdb", 16'(fwdb), 16'd3);
    chk("lu_next_wpcir", 16'(wpcir), 16'd1);
    chk("lu_next_dbub", 16'(dbubble), 16'd0);
    chk("lu_cnt", 16'(stall_cnt), 16'd1);
    tick();

    // Register 0 never forwards or interlocks
    clear_inputs();
    ewreg = 1; em2reg = 1; ern = 0; rs = 0; use_rs = 1;
    #1;
    chk("r0_fwda", 16'(fwda), 16'd0);
    chk("r0_wpcir", 16'(wpcir), 16'd1);
    chk("r0_dbubble", 16'(dbubble), 16'd0);
    tick();
    chk("r0_cnt", 16'(stall_cnt), 16'd1);

    // Slow op: held 3 cycles, released on the 4th (SLOW_CYCLES=2 instance: 1 hold)
    clear_inputs();
    eslow = 1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("slow_wpcir_c%0d", i), 16'(wpcir), (i < 4) ? 16'd0 : 16'd1);
      chk($sformatf("slow_eholdn_c%0d", i), 16'(eholdn), (i < 4) ? 16'd0 : 16'd1);
      chk($sformatf("slow_dbub_c%0d", i), 16'(dbubble), 16'd0);
      if (i <= 2) chk($sformatf("slow2_wpcir_c%0d", i), 16'(wpcir2), (i == 1) ? 16'd0 : 16'd1);
      tick();
    end
    eslow = 0;
    #1;
    chk("slow_cnt", 16'(stall_cnt), 16'd4);
    chk("slow2_cnt", stall_cnt2, 16'd3);

    // eslow and load-use together: hold wins, load-use re-evaluated in LAST
    ewreg = 1; em2reg = 1; ern = 7; rs = 7; use_rs = 1; eslow = 1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("both_wpcir_c%0d", i), 16'(wpcir), 16'd0);
      chk($sformatf("both_dbub_c%0d", i), 16'(dbubble), (i < 4) ? 16'd0 : 16'd1);
      chk($sformatf("both_eholdn_c%0d", i), 16'(eholdn), (i < 4) ? 16'd0 : 16'd1);
      tick();
    end
    clear_inputs();
    #1;
    chk("both_cnt", 16'(stall_cnt), 16'd8);

    // Reset asserted mid-BUSY
    eslow = 1;
    tick();
    #1;
    chk("busy_eholdn", 16'(eholdn), 16'd0);
    eslow = 0;
    resetn = 1'b0;
    #1;
    chk("midrst_wpcir", 16'(wpcir), 16'd1);
    chk("midrst_eholdn", 16'(eholdn), 16'd1);
    chk("midrst_cnt", 16'(stall_cnt), 16'd0);
    #1;
    resetn = 1'b1;
    tick();
    eslow = 1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("restart_wpcir_c%0d", i), 16'(wpcir), (i < 4) ? 16'd0 : 16'd1);
      tick();
    end
    clear_inputs();
    #1;
    chk("restart_cnt", 16'(stall_cnt), 16'd3);

    // Saturation of the 4-bit counter over 20 stall cycles
    ewreg = 1; em2reg = 1; ern = 7; rs = 7; use_rs = 1;
    for (int i = 0; i < 11; i++) tick();
    chk("sat_pre", 16'(stall_cnt), 16'd14);
    for (int i = 0; i < 9; i++) tick();
    chk("sat_hold", 16'(stall_cnt), 16'd15);
    chk("sat_still_stall", 16'(wpcir), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
